// File: rtl/fifo_uart_tx.sv
// Drain side of the byte FIFO: fetches one byte at a time with a single-cycle
// read strobe and serialises it as a UART frame (start, 8 data LSB first, optional parity, stop).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              PAR_EN    = (PARITY == 1) || (PARITY == 2);
    localparam logic              PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_LOAD, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_par;
    logic              w_par_next;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_cnt;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_bit_end;

    function automatic logic parity_bit(input logic [7:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign tx        = r_tx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable && !fifo_empty) w_state_next = S_REQ;
            S_REQ:   w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_START;
            S_START: if (w_bit_end) w_state_next = S_DATA;
            S_DATA:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_state_next = PAR_EN ? S_PAR : S_STOP;
            S_PAR:   if (w_bit_end) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The line level is decoded from the next state so tx leaves a flop with no combinational path.
    always_comb begin
        fifo_read    = (r_state == S_REQ);
        busy         = (r_state != S_IDLE);
        byte_done    = (r_state == S_STOP) && w_bit_end;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        if (r_state == S_LOAD) begin
            w_shift_next = fifo_data;
            w_par_next   = parity_bit(fifo_data);
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            S_PAR:   w_tx_next = w_par_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;
            case (r_state)
                S_LOAD:                         r_baud <= '0;
                S_START, S_DATA, S_PAR, S_STOP: r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
                default:                        r_baud <= r_baud;
            endcase
            if ((r_state == S_START) && w_bit_end) begin
                r_bit_cnt <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three lanes (PARITY 0/1/2, 4 clocks per bit) fed by queue-style FIFO
// models; the monitor decodes every frame from tx and compares with bytes the FIFO handed over.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en       [3] = '{1'b0, 1'b0, 1'b0};
    logic       empty_r  [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] data_r   [3] = '{8'h00, 8'h00, 8'h00};
    logic       rd_w     [3];
    logic       tx_w     [3];
    logic       busy_w   [3];
    logic       done_w   [3];

    always #5 clock = ~clock;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_dut0 (
        .clock(clock), .reset(reset), .enable(en[0]), .fifo_empty(empty_r[0]), .fifo_data(data_r[0]),
        .fifo_read(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .byte_done(done_w[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_dut1 (
        .clock(clock), .reset(reset), .enable(en[1]), .fifo_empty(empty_r[1]), .fifo_data(data_r[1]),
        .fifo_read(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .byte_done(done_w[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_dut2 (
        .clock(clock), .reset(reset), .enable(en[2]), .fifo_empty(empty_r[2]), .fifo_data(data_r[2]),
        .fifo_read(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .byte_done(done_w[2]));

    logic [7:0] fmem [3][64];
    int         fwr  [3] = '{0, 0, 0};
    int         frd  [3] = '{0, 0, 0};
    logic [7:0] emem [3][64];
    int         ewr  [3] = '{0, 0, 0};
    int         erd  [3] = '{0, 0, 0};
    logic       pend [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] pdat [3];

    // FIFO model: data appears the cycle after the strobe, 0 otherwise; popped bytes go to the scoreboard.
    always @(posedge clock) begin
        #1;
        for (int l = 0; l < 3; l++) begin
            data_r[l] = pend[l] ? pdat[l] : 8'h00;
            pend[l]   = 1'b0;
            if (rd_w[l] && (fwr[l] != frd[l])) begin
                pdat[l] = fmem[l][frd[l] % 64];
                frd[l]++;
                pend[l] = 1'b1;
                emem[l][ewr[l] % 64] = pdat[l];
                ewr[l]++;
            end
            empty_r[l] = (fwr[l] == frd[l]);
        end
    end

    int   err = 0, chk = 0;
    logic chk_rel = 1'b0, chk_gap = 1'b0, final_req = 1'b0, final_done = 1'b0;
    logic prev_rst = 1'b1;
    logic prev_en [3] = '{1'b0, 1'b0, 1'b0};
    logic prev_empty [3] = '{1'b1, 1'b1, 1'b1};
    int   rel_cnt = 0;
    logic in_fr [3] = '{1'b0, 1'b0, 1'b0};
    int   cyc [3], since_rd [3] = '{99, 99, 99}, gap [3] = '{99, 99, 99};
    logic lvl [3][11];
    logic glitch [3], dbad [3], bbad [3];
    logic after_done [3] = '{1'b0, 1'b0, 1'b0};
    logic rel_first [3] = '{1'b1, 1'b1, 1'b1};
    int   mlen, mb;
    logic [7:0] dec, eb;
    logic ep;

    task automatic chk_eq(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (prev_rst) rel_cnt = 0;
        else rel_cnt++;
        for (int l = 0; l < 3; l++) begin
            mlen = (10 + ((l != 0) ? 1 : 0)) * CPB;
            if (prev_rst) begin
                chk_eq("reset_tx", int'(tx_w[l]), 1);
                chk_eq("reset_busy", int'(busy_w[l]), 0);
                chk_eq("reset_read", int'(rd_w[l]), 0);
                chk_eq("reset_done", int'(done_w[l]), 0);
                in_fr[l] = 1'b0; erd[l] = ewr[l]; since_rd[l] = 99; gap[l] = 99;
                after_done[l] = 1'b0; rel_first[l] = 1'b1;
            end else begin
                if (rd_w[l]) begin
                    chk_eq("read_rule", int'(prev_en[l] && !prev_empty[l] && !in_fr[l] && (since_rd[l] > 3)), 1);
                    chk_eq("read_vs_done", int'(done_w[l]), 0);
                    if ((l == 0) && rel_first[0] && chk_rel) chk_eq("first_read_latency", rel_cnt, 1);
                    rel_first[l] = 1'b0;
                    since_rd[l] = 0;
                end else if (since_rd[l] < 99) begin
                    since_rd[l]++;
                end
                if (after_done[l]) begin
                    chk_eq("idle_after_done_busy", int'(busy_w[l]), 0);
                    chk_eq("idle_after_done_tx", int'(tx_w[l]), 1);
                    after_done[l] = 1'b0;
                end
                if (!in_fr[l]) begin
                    if (tx_w[l] == 1'b0) begin
                        chk_eq("start_latency", since_rd[l], 2);
                        if ((l == 0) && chk_gap) chk_eq("b2b_gap", gap[l], 3);
                        in_fr[l] = 1'b1; cyc[l] = 0;
                        glitch[l] = 1'b0; dbad[l] = 1'b0; bbad[l] = 1'b0;
                    end else if (gap[l] < 99) begin
                        gap[l]++;
                    end
                end
                if (in_fr[l]) begin
                    mb = cyc[l] / CPB;
                    if (cyc[l] % CPB == 0) lvl[l][mb] = tx_w[l];
                    else if (tx_w[l] != lvl[l][mb]) glitch[l] = 1'b1;
                    if (!busy_w[l]) bbad[l] = 1'b1;
                    if (done_w[l] != (cyc[l] == mlen - 1)) dbad[l] = 1'b1;
                    cyc[l]++;
                    if (cyc[l] == mlen) begin
                        for (int i = 0; i < 8; i++) dec[i] = lvl[l][1 + i];
                        chk_eq("exp_avail", int'(erd[l] != ewr[l]), 1);
                        if (erd[l] != ewr[l]) begin
                            eb = emem[l][erd[l] % 64];
                            erd[l]++;
                        end else begin
                            eb = dec;
                        end
                        chk_eq("byte", int'(dec), int'(eb));
                        if (l != 0) begin
                            ep = (($countones(eb) % 2) == 1) ^ (l == 2);
                            chk_eq("parity_bit", int'(lvl[l][9]), int'(ep));
                        end
                        chk_eq("stop_bit", int'(lvl[l][mlen / CPB - 1]), 1);
                        chk_eq("bit_glitch", int'(glitch[l]), 0);
                        chk_eq("done_timing", int'(dbad[l]), 0);
                        chk_eq("busy_in_frame", int'(bbad[l]), 0);
                        in_fr[l] = 1'b0; gap[l] = 0; after_done[l] = 1'b1;
                    end
                end
            end
        end
        if (final_req && !final_done) begin
            for (int l = 0; l < 3; l++) begin
                chk_eq("fifo_drained", fwr[l] - frd[l], 0);
                chk_eq("scoreboard_drained", ewr[l] - erd[l], 0);
                chk_eq("frame_open", int'(in_fr[l]), 0);
            end
            final_done = 1'b1;
        end
        prev_rst = reset;
        for (int l = 0; l < 3; l++) begin
            prev_en[l]    = en[l];
            prev_empty[l] = empty_r[l];
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input int l, input logic [7:0] b);
        fmem[l][fwr[l] % 64] = b;
        fwr[l]++;
    endtask

    function automatic logic all_idle();
        for (int l = 0; l < 3; l++)
            if ((fwr[l] != frd[l]) || (erd[l] != ewr[l]) || in_fr[l] || busy_w[l]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int max);
        int n = 0;
        while ((n < max) && !all_idle()) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    task automatic wait_frame(input int min_cyc, input int max);
        int n = 0;
        while ((n < max) && !(in_fr[0] && (cyc[0] >= min_cyc))) begin
            tick();
            n++;
        end
    endtask

    initial begin
        // Reset held with data available; fetch begins right after release, then 0xA5 goes out.
        push(0, 8'hA5);
        en[0] = 1'b1;
        chk_rel = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        wait_idle(200);
        chk_rel = 1'b0;

        push(0, 8'h07); push(1, 8'h07); push(2, 8'h07);
        en[1] = 1'b1; en[2] = 1'b1;
        wait_idle(200);

        push(0, 8'h00); push(0, 8'hFF);
        wait_frame(0, 200);
        chk_gap = 1'b1;
        wait_idle(300);
        chk_gap = 1'b0;

        repeat (100) tick();
        en[0] = 1'b0;
        push(0, 8'h5A);
        repeat (100) tick();
        en[0] = 1'b1;
        wait_frame(3 * CPB, 200);
        push(0, 8'h11);
        en[0] = 1'b0;
        for (int n = 0; (n < 200) && (in_fr[0] || busy_w[0]); n++) tick();
        repeat (30) tick();
        en[0] = 1'b1;
        wait_idle(200);

        // Reset lands inside data bit 3 of 0x3C; the popped byte is dropped.
        push(0, 8'h3C);
        wait_frame(4 * CPB + 1, 200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(0, 8'h81);
        wait_idle(200);

        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < 3; l++) en[l] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) push(int'($urandom_range(0, 2)), 8'($urandom));
            tick();
        end
        for (int l = 0; l < 3; l++) en[l] = 1'b1;
        wait_idle(3000);

        final_req = 1'b1;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
